// File: rtl/seg_display_driver.sv
// rtl/seg_display_driver.sv - signed 32-bit to 8-digit multiplexed seven-segment driver
// Serial double-dabble conversion; display registers swap atomically when a conversion finishes.
module seg_display_driver #(
  parameter int SCAN_DIV = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] num,
  output logic [7:0]  SEGMENT,
  output logic [7:0]  AN,
  output logic        busy,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  localparam logic [7:0] GLYPH_MINUS = 8'hBF;
  localparam logic [7:0] GLYPH_E     = 8'h86;
  localparam logic [7:0] GLYPH_R     = 8'hAF;
  localparam logic [7:0] GLYPH_BLANK = 8'hFF;

  state_t                state_q, state_d;
  logic                  valid_q, valid_d;
  logic [31:0]           last_q, last_d;
  logic                  sign_q, sign_d;
  logic [31:0]           mag_q, mag_d;
  logic [39:0]           bcd_q, bcd_d;
  logic [4:0]            bit_cnt_q, bit_cnt_d;
  logic [63:0]           disp_q, disp_d;
  logic                  ovf_q, ovf_d;
  logic [SCAN_DIV-1:0]   scan_q, scan_d;
  logic [7:0]            an_q, an_d;
  logic [7:0]            seg_q, seg_d;

  logic [39:0]           bcd_adj;
  logic [71:0]           shift_val;
  logic [63:0]           glyph_next;
  logic                  ovf_calc;
  logic [2:0]            msd;
  logic [2:0]            sel;

  function automatic logic [7:0] seg_glyph(input logic [3:0] d);
    case (d)
      4'd0:    seg_glyph = 8'hC0;
      4'd1:    seg_glyph = 8'hF9;
      4'd2:    seg_glyph = 8'hA4;
      4'd3:    seg_glyph = 8'hB0;
      4'd4:    seg_glyph = 8'h99;
      4'd5:    seg_glyph = 8'h92;
      4'd6:    seg_glyph = 8'h82;
      4'd7:    seg_glyph = 8'hF8;
      4'd8:    seg_glyph = 8'h80;
      4'd9:    seg_glyph = 8'h90;
      default: seg_glyph = GLYPH_BLANK;
    endcase
  endfunction

  // Double-dabble step: correct every nibble >= 5 before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 10; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end
    shift_val = {bcd_adj, mag_q} << 1;
  end

  // Glyph image built from the finished BCD; msd = most significant non-zero digit (0 if value is 0).
  always_comb begin
    ovf_calc   = sign_q ? (bcd_q[39:28] != 12'd0) : (bcd_q[39:32] != 8'd0);
    msd        = 3'd0;
    glyph_next = '1;
    for (int i = 1; i < 8; i++) begin
      if (bcd_q[i*4 +: 4] != 4'd0) begin
        msd = 3'(i);
      end
    end
    for (int i = 0; i < 8; i++) begin
      if (ovf_calc) begin
        if (i == 2) begin
          glyph_next[i*8 +: 8] = GLYPH_E;
        end else if (i < 2) begin
          glyph_next[i*8 +: 8] = GLYPH_R;
        end else begin
          glyph_next[i*8 +: 8] = GLYPH_BLANK;
        end
      end else if (i <= int'(msd)) begin
        glyph_next[i*8 +: 8] = seg_glyph(bcd_q[i*4 +: 4]);
      end else if (sign_q && (i == int'(msd) + 1)) begin
        glyph_next[i*8 +: 8] = GLYPH_MINUS;
      end else begin
        glyph_next[i*8 +: 8] = GLYPH_BLANK;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    last_d    = last_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    bcd_d     = bcd_q;
    bit_cnt_d = bit_cnt_q;
    disp_d    = disp_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (!valid_q || (num != last_q)) begin
          last_d    = num;
          sign_d    = num[31];
          mag_d     = num[31] ? (~num + 32'd1) : num;
          bcd_d     = '0;
          bit_cnt_d = '0;
          state_d   = CONV;
        end
      end
      CONV: begin
        bcd_d     = shift_val[71:32];
        mag_d     = shift_val[31:0];
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd31) begin
          state_d = DONE;
        end
      end
      DONE: begin
        disp_d  = glyph_next;
        ovf_d   = ovf_calc;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan runs continuously; AN and SEGMENT are registered from the same select.
  always_comb begin
    sel    = scan_q[SCAN_DIV-1 -: 3];
    scan_d = scan_q + {{(SCAN_DIV-1){1'b0}}, 1'b1};
    an_d   = ~(8'h01 << sel);
    seg_d  = disp_q[{sel, 3'b000} +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      last_q    <= '0;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      bcd_q     <= '0;
      bit_cnt_q <= '0;
      disp_q    <= '1;
      ovf_q     <= 1'b0;
      scan_q    <= '0;
      an_q      <= 8'hFF;
      seg_q     <= 8'hFF;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      sign_q    <= sign_d;
      mag_q     <= mag_d;
      bcd_q     <= bcd_d;
      bit_cnt_q <= bit_cnt_d;
      disp_q    <= disp_d;
      ovf_q     <= ovf_d;
      scan_q    <= scan_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign SEGMENT = seg_q;
  assign AN      = an_q;
  assign busy    = (state_q != IDLE);
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_seg_display_driver.sv
// tb/tb_seg_display_driver.sv - self-checking bench for seg_display_driver (SCAN_DIV=4)
module tb_seg_display_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] num;
  logic [7:0]  SEGMENT;
  logic [7:0]  AN;
  logic        busy;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  seg_display_driver #(.SCAN_DIV(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .num     (num),
    .SEGMENT (SEGMENT),
    .AN      (AN),
    .busy    (busy),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] glyph_of(input int d);
    logic [7:0] lut [10];
    lut = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    return lut[d];
  endfunction

  function automatic bit model_ovf(input logic [31:0] n);
    longint v;
    v = $signed(n);
    if (v < 0) return (-v) > 64'sd9999999;
    return v > 64'sd99999999;
  endfunction

  // Expected digit glyphs {d7..d0} computed by plain decimal arithmetic.
  function automatic logic [63:0] model_disp(input logic [31:0] n);
    logic [63:0] r;
    longint      v;
    longint      m;
    bit          neg;
    int          k;
    r   = {8{8'hFF}};
    v   = $signed(n);
    neg = (v < 0);
    m   = neg ? -v : v;
    if (model_ovf(n)) begin
      r[23:16] = 8'h86;
      r[15:8]  = 8'hAF;
      r[7:0]   = 8'hAF;
      return r;
    end
    k = 0;
    do begin
      r[k*8 +: 8] = glyph_of(int'(m % 10));
      m = m / 10;
      k++;
    end while (m != 0);
    if (neg) r[k*8 +: 8] = 8'hBF;
    return r;
  endfunction

  function automatic int an_sel(input logic [7:0] a);
    for (int i = 0; i < 8; i++) begin
      if (a == ~(8'h01 << i)) return i;
    end
    return -1;
  endfunction

  task automatic capture(output logic [63:0] got);
    int s;
    got = '0;
    for (int t = 0; t < 16; t++) begin
      s = an_sel(AN);
      if (s >= 0) got[s*8 +: 8] = SEGMENT;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy still %b after %0d cycles, required 0", busy, n);
    end
  endtask

  // Drive a new value at a negedge and return at the first negedge where the new glyphs are shown.
  task automatic run_conv(input logic [31:0] v);
    num = v;
    @(negedge clk);
    wait_idle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    int          bc;
    logic [63:0] got;
    rst = 1'b1;
    num = 32'd0;
    repeat (2) @(negedge clk);
    checks++; if (AN !== 8'hFF) begin errors++; $display("FAIL reset_an: got %h want ff", AN); end
    checks++; if (SEGMENT !== 8'hFF) begin errors++; $display("FAIL reset_seg: got %h want ff", SEGMENT); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    rst = 1'b0;
    @(negedge clk);
    bc = 0;
    while (busy === 1'b1 && bc < 200) begin
      bc++;
      @(negedge clk);
    end
    checks++; if (bc != 33) begin errors++; $display("FAIL reset_busy_len: got %0d want 33", bc); end
    @(negedge clk);
    capture(got);
    checks++; if (got !== model_disp(32'd0)) begin errors++; $display("FAIL reset_zero_disp: got %h want %h", got, model_disp(32'd0)); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_zero_ovf: got %b want 0", ovf); end
  endtask

  task automatic test_values(input string name, input logic [31:0] vals [$]);
    logic [63:0] got;
    foreach (vals[i]) begin
      run_conv(vals[i]);
      capture(got);
      checks++;
      if (got !== model_disp(vals[i])) begin
        errors++;
        $display("FAIL %s_disp[%0d] num=%h: got %h want %h", name, i, vals[i], got, model_disp(vals[i]));
      end
      checks++;
      if (ovf !== model_ovf(vals[i])) begin
        errors++;
        $display("FAIL %s_ovf[%0d] num=%h: got %b want %b", name, i, vals[i], ovf, model_ovf(vals[i]));
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] vals [$];
    vals = '{32'd12345678, 32'hFFFFFFD6, 32'd99999999, 32'd1, 32'hFFFFFFFF, 32'd1000};
    test_values("basic", vals);
  endtask

  task automatic test_overflow();
    logic [31:0] vals [$];
    vals = '{32'd100000000, 32'hFF676980, 32'hFF676981, 32'h80000000, 32'h7FFFFFFF};
    test_values("ovf", vals);
  endtask

  task automatic test_random();
    logic [31:0] vals [$];
    logic [31:0] v;
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom;
        1:       v = $urandom_range(0, 99999999);
        2:       v = 32'd0 - $urandom_range(1, 9999999);
        default: v = 32'd0 - $urandom_range(0, 999);
      endcase
      vals.push_back(v);
    end
    test_values("rand", vals);
  endtask

  task automatic test_latency();
    logic [63:0] old_d;
    logic [63:0] new_d;
    int          s;
    run_conv(32'd0);
    old_d = model_disp(32'd0);
    new_d = model_disp(32'd12345678);
    num = 32'd12345678;
    @(negedge clk);
    repeat (33) @(negedge clk);
    s = an_sel(AN);
    checks++;
    if (s < 0 || SEGMENT !== old_d[s*8 +: 8]) begin
      errors++;
      $display("FAIL latency_33: AN=%h SEGMENT=%h, required old glyph", AN, SEGMENT);
    end
    @(negedge clk);
    s = an_sel(AN);
    checks++;
    if (s < 0 || SEGMENT !== new_d[s*8 +: 8]) begin
      errors++;
      $display("FAIL latency_34: AN=%h SEGMENT=%h, required new glyph", AN, SEGMENT);
    end
  endtask

  task automatic test_ignore_change();
    logic [63:0] got;
    num = 32'd5;
    @(negedge clk);
    repeat (10) @(negedge clk);
    num = 32'd7;
    wait_idle();
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ignore_reconv_busy: got %b want 1", busy); end
    capture(got);
    checks++; if (got !== model_disp(32'd5)) begin errors++; $display("FAIL ignore_first: got %h want %h", got, model_disp(32'd5)); end
    wait_idle();
    @(negedge clk);
    capture(got);
    checks++; if (got !== model_disp(32'd7)) begin errors++; $display("FAIL ignore_second: got %h want %h", got, model_disp(32'd7)); end
  endtask

  task automatic test_reset_mid_conv();
    logic [63:0] got;
    num = 32'hFFFFEFFF;
    @(negedge clk);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (AN !== 8'hFF) begin errors++; $display("FAIL midrst_an: got %h want ff", AN); end
    checks++; if (SEGMENT !== 8'hFF) begin errors++; $display("FAIL midrst_seg: got %h want ff", SEGMENT); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_restart: got %b want 1", busy); end
    wait_idle();
    @(negedge clk);
    capture(got);
    checks++; if (got !== model_disp(32'hFFFFEFFF)) begin errors++; $display("FAIL midrst_disp: got %h want %h", got, model_disp(32'hFFFFEFFF)); end
  endtask

  task automatic test_scan();
    logic [7:0] an_s [40];
    int         j;
    for (int t = 0; t < 40; t++) begin
      an_s[t] = AN;
      @(negedge clk);
    end
    j = -1;
    for (int t = 17; t >= 1; t--) begin
      if (an_s[t] == 8'hFE && an_s[t-1] != 8'hFE) j = t;
    end
    checks++;
    if (j < 0) begin
      errors++;
      $display("FAIL scan_start: no FE digit start found, first AN=%h", an_s[0]);
    end else begin
      for (int k = 0; k < 16; k++) begin
        checks++;
        if (an_s[j+k] !== ~(8'h01 << (k / 2))) begin
          errors++;
          $display("FAIL scan_seq[%0d]: got %h want %h", k, an_s[j+k], ~(8'h01 << (k / 2)));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_random();
    test_latency();
    test_ignore_change();
    test_reset_mid_conv();
    test_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
